// File: rtl/register_file.sv
// 32 x WIDTH register file: two combinational read ports, one write port, X31 reads as zero.
// Latency: reads 0 cycles (same-cycle write bypass); writes land on the next rising clk edge.
// Backpressure: none; every write and read is accepted each cycle.
module register_file #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RegWrite,
   input  logic [4:0]       WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [4:0]       ReadRegister1,
   input  logic [4:0]       ReadRegister2,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2
);

   localparam logic [4:0] ZERO_REG = 5'd31;

   logic [WIDTH-1:0] regs [31];
   logic [WIDTH-1:0] leaf [32];
   logic [30:0]      wr_en;
   logic [WIDTH-1:0] tree1;
   logic [WIDTH-1:0] tree2;
   logic             byp1;
   logic             byp2;

   // Enables stay low whenever RegWrite is low, so an unknown index cannot reach state.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < 31; i++) begin
         if (RegWrite && (WriteRegister == 5'(i))) begin
            wr_en[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 31; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 31; i++) begin
            if (wr_en[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 31; i++) begin
         leaf[i] = regs[i];
      end
      leaf[31] = '0;
   end

   // Five levels of 2:1 selection, index bit 0 at the leaves up to bit 4 at the root.
   function automatic logic [WIDTH-1:0] tree_read(input logic [WIDTH-1:0] v [32],
                                                  input logic [4:0]       idx);
      logic [WIDTH-1:0] t [32];
      t = v;
      for (int lvl = 0; lvl < 5; lvl++) begin
         for (int n = 0; n < (16 >> lvl); n++) begin
            t[n] = idx[lvl] ? t[2*n+1] : t[2*n];
         end
      end
      return t[0];
   endfunction

   always_comb begin
      tree1 = tree_read(leaf, ReadRegister1);
      tree2 = tree_read(leaf, ReadRegister2);
   end

   assign byp1 = RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG);
   assign byp2 = RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG);

   assign ReadData1 = reset ? '0 : (byp1 ? WriteData : tree1);
   assign ReadData2 = reset ? '0 : (byp2 ? WriteData : tree2);

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model.
module tb_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] mem [31];

   register_file #(.WIDTH(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   always #10 clk = ~clk;

   // Reference: what a read port must show given the currently driven inputs.
   function automatic logic [63:0] exp_read(input logic [4:0] idx);
      if (reset) return 64'd0;
      if (idx == 5'd31) return 64'd0;
      if (RegWrite && WriteRegister == idx) return WriteData;
      return mem[idx];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 31; i++) mem[i] = 64'd0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = a;
      WriteData     = d;
      @(posedge clk);
      if (a != 5'd31) mem[a] = d;
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      RegWrite  = 1'b1;
      WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
      clear_model();
      for (int i = 0; i < 32; i++) begin
         WriteRegister = 5'(i);
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         #1;
         n_checks++;
         if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_read idx=%0d rd1=%h rd2=%h want 0", i, ReadData1, ReadData2);
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      RegWrite = 1'b0;
      reset    = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(i);
         #1;
         n_checks++;
         if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
            n_errors++;
            $display("FAIL post_reset_read idx=%0d rd1=%h rd2=%h want 0", i, ReadData1, ReadData2);
         end
      end
   endtask

   task automatic test_write_all();
      logic [63:0] want;
      for (int i = 0; i < 31; i++) do_write(5'(i), 64'h0123_4567_89AB_CD00 + 64'(i));
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         want = (i == 31) ? 64'd0 : 64'h0123_4567_89AB_CD00 + 64'(i);
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(i);
         #1;
         n_checks++;
         if (ReadData1 !== want || ReadData2 !== want) begin
            n_errors++;
            $display("FAIL write_all idx=%0d rd1=%h rd2=%h want %h", i, ReadData1, ReadData2, want);
         end
      end
   endtask

   task automatic test_x31();
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd31;
      WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd31;
      #1;
      n_checks++;
      if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
         n_errors++;
         $display("FAIL x31_same_cycle rd1=%h rd2=%h want 0", ReadData1, ReadData2);
      end
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      n_checks++;
      if (ReadData1 !== 64'd0) begin
         n_errors++;
         $display("FAIL x31_after_edge rd1=%h want 0", ReadData1);
      end
      for (int i = 0; i < 31; i++) begin
         ReadRegister2 = 5'(i);
         #1;
         n_checks++;
         if (ReadData2 !== mem[i]) begin
            n_errors++;
            $display("FAIL x31_others idx=%0d rd2=%h want %h", i, ReadData2, mem[i]);
         end
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd5;
      WriteData     = 64'h0000_0000_DEAD_BEEF;
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd5;
      #1;
      n_checks++;
      if (ReadData1 !== 64'hDEAD_BEEF || ReadData2 !== 64'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL bypass_both rd1=%h rd2=%h want deadbeef", ReadData1, ReadData2);
      end
      @(posedge clk);
      mem[5] = 64'hDEAD_BEEF;
      #1;
      RegWrite = 1'b0;
      #1;
      n_checks++;
      if (ReadData1 !== 64'hDEAD_BEEF || ReadData2 !== 64'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL bypass_stored rd1=%h rd2=%h want deadbeef", ReadData1, ReadData2);
      end
      // Port 1 bypassed, port 2 on a different register.
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd6;
      WriteData     = 64'hA5A5_5A5A_0F0F_F0F0;
      ReadRegister1 = 5'd6;
      ReadRegister2 = 5'd7;
      #1;
      n_checks++;
      if (ReadData1 !== 64'hA5A5_5A5A_0F0F_F0F0 || ReadData2 !== mem[7]) begin
         n_errors++;
         $display("FAIL bypass_split rd1=%h rd2=%h want a5a55a5a0f0ff0f0 / %h",
                  ReadData1, ReadData2, mem[7]);
      end
      @(posedge clk);
      mem[6] = 64'hA5A5_5A5A_0F0F_F0F0;
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_no_write();
      @(negedge clk);
      RegWrite      = 1'b0;
      WriteRegister = 5'd7;
      ReadRegister1 = 5'd7;
      for (int k = 0; k < 3; k++) begin
         WriteData = {$urandom, $urandom};
         @(posedge clk);
         #1;
         n_checks++;
         if (ReadData1 !== mem[7]) begin
            n_errors++;
            $display("FAIL no_write edge=%0d rd1=%h want %h", k, ReadData1, mem[7]);
         end
      end
   endtask

   task automatic test_x_index();
      @(negedge clk);
      RegWrite      = 1'b0;
      WriteRegister = 5'bxxxxx;
      WriteData     = 64'bx;
      @(posedge clk);
      #1;
      WriteRegister = 5'd0;
      WriteData     = 64'd0;
      for (int i = 0; i < 31; i++) begin
         ReadRegister1 = 5'(i);
         #1;
         n_checks++;
         if (ReadData1 !== mem[i]) begin
            n_errors++;
            $display("FAIL x_index idx=%0d rd1=%h want %h", i, ReadData1, mem[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] e1;
      logic [63:0] e2;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         RegWrite      = 1'($urandom_range(0, 1));
         WriteRegister = 5'($urandom_range(0, 31));
         WriteData     = {$urandom, $urandom};
         ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
         ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
         #1;
         e1 = exp_read(ReadRegister1);
         e2 = exp_read(ReadRegister2);
         n_checks++;
         if (ReadData1 !== e1 || ReadData2 !== e2) begin
            n_errors++;
            $display("FAIL random it=%0d ra1=%0d ra2=%0d rd1=%h rd2=%h want %h %h",
                     k, ReadRegister1, ReadRegister2, ReadData1, ReadData2, e1, e2);
         end
         @(posedge clk);
         if (RegWrite && WriteRegister != 5'd31) mem[WriteRegister] = WriteData;
      end
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_reset_midcycle();
      do_write(5'd3, 64'h1234);
      @(negedge clk);
      ReadRegister1 = 5'd3;
      ReadRegister2 = 5'd3;
      #1;
      n_checks++;
      if (ReadData1 !== 64'h1234) begin
         n_errors++;
         $display("FAIL pre_reset_x3 rd1=%h want 1234", ReadData1);
      end
      #2;
      reset = 1'b1;
      clear_model();
      #1;
      n_checks++;
      if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
         n_errors++;
         $display("FAIL midcycle_reset_x3 rd1=%h rd2=%h want 0", ReadData1, ReadData2);
      end
      // A write pending while reset is held must not land.
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd9;
      WriteData     = 64'h5555_6666_7777_8888;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      RegWrite = 1'b0;
      ReadRegister1 = 5'd9;
      #1;
      n_checks++;
      if (ReadData1 !== 64'd0) begin
         n_errors++;
         $display("FAIL write_during_reset x9=%h want 0", ReadData1);
      end
      for (int i = 0; i < 31; i++) begin
         ReadRegister2 = 5'(i);
         #1;
         n_checks++;
         if (ReadData2 !== 64'd0) begin
            n_errors++;
            $display("FAIL cleared idx=%0d rd2=%h want 0", i, ReadData2);
         end
      end
      do_write(5'd9, 64'h0BAD_F00D_CAFE_0001);
      #1;
      n_checks++;
      if (ReadData1 !== 64'h0BAD_F00D_CAFE_0001) begin
         n_errors++;
         $display("FAIL first_write_after_reset x9=%h want 0badf00dcafe0001", ReadData1);
      end
   endtask

   initial begin
      reset         = 1'b1;
      RegWrite      = 1'b0;
      WriteRegister = 5'd0;
      WriteData     = 64'd0;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd0;
      test_reset();
      test_write_all();
      test_x31();
      test_bypass();
      test_no_write();
      test_x_index();
      test_random();
      test_reset_midcycle();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 64: data width of every register, write-data port and read port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all register state immediately when asserted.
REQ-004 RegWrite  input  1  write enable for the single write port.
REQ-005 WriteRegister  input  5  destination register index, 0..31.
REQ-006 WriteData  input  WIDTH  data to write.
REQ-007 ReadRegister1  input  5  source index for read port 1.
REQ-008 ReadRegister2  input  5  source index for read port 2.
REQ-009 ReadData1  output  WIDTH  contents of register ReadRegister1.
REQ-010 ReadData2  output  WIDTH  contents of register ReadRegister2.

Function
REQ-011 The block SHALL hold 32 registers X0..X31, each WIDTH bits.
REQ-012 Registers X0..X30 SHALL be writable storage.
REQ-013 X31 SHALL be hardwired zero: writes to it are discarded and reads of it return all zeros.
REQ-014 On a rising clk edge with RegWrite=1 and reset=0, the register at WriteRegister (if not 31) SHALL load WriteData.
REQ-015 Every other register SHALL hold its value on that edge.
REQ-016 With RegWrite=0, no register SHALL change on a clk edge.
REQ-017 Write decode SHALL be one-hot: exactly one enable for indices 0..30 when RegWrite=1, and none otherwise.
REQ-018 Read ports SHALL be combinational, with zero cycles of latency from a ReadRegister change to the corresponding ReadData change.
REQ-019 Read ports SHALL be independent; both ports addressing the same register SHALL return identical data.
REQ-020 Same-cycle bypass: when RegWrite=1, WriteRegister equals a read index, and that index is not 31, that read port SHALL return WriteData combinationally in the same cycle.
REQ-021 The stored value for a bypassed register SHALL update at the next rising edge as normal.
REQ-022 A bypass on port 1 and a bypass on port 2 SHALL be independent; both may be active at once.
REQ-023 A write to X31 SHALL NOT trigger a bypass, so a read of X31 stays zero.
REQ-024 Each read port SHALL be a 32:1 selection over the 32 register outputs, with X31 forced to zero.
REQ-025 The 32:1 selection SHALL be built as a 5-level tree of 2:1 selectors indexed by ReadRegister bits 0 (first level) to 4 (last level).
REQ-026 Unknown (X) index bits with RegWrite=0 SHALL NOT corrupt stored state.

Reset
REQ-027 While reset=1, all registers X0..X30 SHALL be 0, independent of clk.
REQ-028 While reset=1, ReadData1 and ReadData2 SHALL read 0 for any index, with bypass suppressed.
REQ-029 A reset asserted mid-cycle, including during a write, SHALL clear all registers immediately; the pending write SHALL be lost.
REQ-030 After reset deasserts, the first rising clk edge with RegWrite=1 SHALL perform a normal write.

Verification
REQ-031 Assert reset, then read all 32 indices on both ports -> every read returns 0.
REQ-032 Write X(i)=64'h0123_4567_89AB_CD00+i for i=0..30, then read all indices -> each read returns its written value, and X31 returns 0.
REQ-033 Write X31=64'hFFFF_FFFF_FFFF_FFFF with ReadRegister1=31 -> ReadData1=0 in the same cycle and after the edge; no other register changes.
REQ-034 Write X5=64'hDEAD_BEEF with ReadRegister1=ReadRegister2=5 -> both ports show 64'hDEAD_BEEF before the edge (bypass), and X5 holds it after the edge.
REQ-035 Set RegWrite=0 and WriteRegister=7 with new data, over 3 clock edges -> X7 is unchanged.
REQ-036 Write X3=64'h1234, then pulse reset between clk edges -> ReadData for X3 is 0 immediately, before the next edge.
